// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcode encodings, flag bit positions,
// the per-entry control fields and the condition-code helper.
package ex_pkg;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_ADC = 5'b00010;
  localparam logic [4:0] OP_ADZ = 5'b00011;
  localparam logic [4:0] OP_ADL = 5'b00100;
  localparam logic [4:0] OP_NDU = 5'b00101;
  localparam logic [4:0] OP_NDC = 5'b00110;
  localparam logic [4:0] OP_NDZ = 5'b00111;
  localparam logic [4:0] OP_LHI = 5'b01000;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

  typedef logic [1:0] flags_t;

  typedef struct packed {
    logic   wb_en;
    flags_t flags;
  } ex_ctrl_t;

  // Conditional opcodes gate on the speculative flags; everything else always runs.
  function automatic logic cond_met(input logic [4:0] op, input flags_t f);
    case (op)
      OP_ADC, OP_NDC: return f[FLAG_C];
      OP_ADZ, OP_NDZ: return f[FLAG_Z];
      default:        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// Upstream/downstream handshake bundle of the execute stage.
// The stage itself connects through the slave modport.
interface ex_stage_pipe_if #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3,
  parameter int TAG_W = 2
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [WIDTH-1:0] in_opa;
  logic [WIDTH-1:0] in_opb;
  logic [RA_W-1:0]  in_rd;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_opa;
  logic [RA_W-1:0]  out_rd;
  logic [TAG_W-1:0] out_tag;
  logic             out_wb_en;
  logic [1:0]       out_flags;

  modport master (
    output in_valid, in_op, in_opa, in_opb, in_rd, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_opa, out_rd, out_tag, out_wb_en, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_opa, in_opb, in_rd, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_opa, out_rd, out_tag, out_wb_en, out_flags
  );
endinterface

// File: rtl/ex_alu.sv
// Combinational ALU of the execute stage. Flags pass through untouched unless the
// executed opcode produces them; a failed condition or unknown opcode is a NOP.
module ex_alu
  import ex_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LHI_BITS = 9
) (
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  flags_t           flags,
  output logic [WIDTH-1:0] res,
  output flags_t           new_flags,
  output logic             wb_en
);
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nand_res;

  // ADL shifts B left by one and drops the bit shifted out of the datapath.
  assign addend   = (op == OP_ADL) ? {b[WIDTH-2:0], 1'b0} : b;
  assign sum      = {1'b0, a} + {1'b0, addend};
  assign nand_res = ~(a & b);

  always_comb begin
    res       = '0;
    new_flags = flags;
    wb_en     = 1'b0;
    if (cond_met(op, flags)) begin
      case (op)
        OP_ADD, OP_ADC, OP_ADZ, OP_ADL: begin
          res               = sum[WIDTH-1:0];
          new_flags[FLAG_C] = sum[WIDTH];
          new_flags[FLAG_Z] = ~|sum[WIDTH-1:0];
          wb_en             = 1'b1;
        end
        OP_NDU, OP_NDC, OP_NDZ: begin
          res               = nand_res;
          new_flags[FLAG_Z] = ~|nand_res;
          wb_en             = 1'b1;
        end
        OP_LHI: begin
          res   = {b[LHI_BITS-1:0], {(WIDTH-LHI_BITS){1'b0}}};
          wb_en = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ex_skid_buf.sv
// Two-entry output FIFO that decouples in_ready from out_ready.
// Push is refused while full; flush empties both entries.
module ex_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          valid,
  output logic [DW-1:0] data
);
  logic [DW-1:0] mem_reg [2];
  logic          rd_ptr_reg;
  logic          wr_ptr_reg;
  logic [1:0]    count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == 2'd2);
  assign valid   = (count_reg != 2'd0);
  assign data    = mem_reg[rd_ptr_reg];
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
    end else if (flush) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/ex_stage_pipe.sv
// Registered IITB RISC execute stage with speculative/committed C,Z flags.
// Define EX_SKID_EN to place a two-entry skid buffer on the output.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LHI_BITS = 9,
  parameter int RA_W     = 3,
  parameter int TAG_W    = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  ex_stage_pipe_if.slave  bus
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] opa;
    logic [RA_W-1:0]  rd;
    logic [TAG_W-1:0] tag;
    ex_ctrl_t         ctrl;
  } entry_t;

  entry_t           new_entry;
  entry_t           out_entry;
  logic             out_valid;
  logic             in_ready;
  logic             accept;
  logic             out_hs;
  flags_t           spec_flags_reg;
  flags_t           commit_flags_reg;
  flags_t           alu_flags;
  logic [WIDTH-1:0] alu_res;
  logic             alu_wb_en;

  ex_alu #(.WIDTH(WIDTH), .LHI_BITS(LHI_BITS)) u_alu (
    .op        (bus.in_op),
    .a         (bus.in_opa),
    .b         (bus.in_opb),
    .flags     (spec_flags_reg),
    .res       (alu_res),
    .new_flags (alu_flags),
    .wb_en     (alu_wb_en)
  );

  assign accept    = bus.in_valid & in_ready;
  assign out_hs    = out_valid & bus.out_ready;
  assign new_entry = {alu_res, bus.in_opa, bus.in_rd, bus.in_tag, alu_wb_en, alu_flags};

`ifdef EX_SKID_EN
  logic skid_full;

  ex_skid_buf #(.DW($bits(entry_t))) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .push      (accept & ~flush),
    .push_data (new_entry),
    .pop       (bus.out_ready),
    .full      (skid_full),
    .valid     (out_valid),
    .data      (out_entry)
  );

  assign in_ready = ~skid_full;
`else
  assign in_ready = ~out_valid | bus.out_ready;

  // A new accept overwrites the entry leaving this cycle, so streaming has no bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_entry <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_entry <= new_entry;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // On flush the speculative flags fall back to the newest committed value,
  // which includes an entry retiring in that same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spec_flags_reg   <= '0;
      commit_flags_reg <= '0;
    end else begin
      if (out_hs) commit_flags_reg <= out_entry.ctrl.flags;
      if (flush) begin
        spec_flags_reg <= out_hs ? out_entry.ctrl.flags : commit_flags_reg;
      end else if (accept) begin
        spec_flags_reg <= alu_flags;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_entry.result;
  assign bus.out_opa    = out_entry.opa;
  assign bus.out_rd     = out_entry.rd;
  assign bus.out_tag    = out_entry.tag;
  assign bus.out_wb_en  = out_entry.ctrl.wb_en;
  assign bus.out_flags  = out_entry.ctrl.flags;
endmodule
